// File: rtl/irq_timer_pkg.sv
// rtl/irq_timer_pkg.sv - shared constants and types for the bus interval timer
package irq_timer_pkg;

  // Register offsets within the 8-byte block, selected by ab[2:0]
  localparam logic [2:0] OFS_CNT_L  = 3'd0;
  localparam logic [2:0] OFS_CNT_H  = 3'd1;
  localparam logic [2:0] OFS_LAT_L  = 3'd2;
  localparam logic [2:0] OFS_LAT_H  = 3'd3;
  localparam logic [2:0] OFS_CTRL   = 3'd4;
  localparam logic [2:0] OFS_STATUS = 3'd5;

  // CTRL register bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 16-bit down counter with load, reload, enable and zero flag
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load, load_val   software load (highest priority)
//   reload, reload_val  auto-reload on expiry
//   dec              decrement request; ignored at zero
//   count            current counter value
//   zero             count == 0
module timer_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        reload,
  input  logic [15:0] reload_val,
  input  logic        dec,
  output logic [15:0] count,
  output logic        zero
);

  assign zero = (count == 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (load) begin
      count <= load_val;
    end else if (reload) begin
      count <= reload_val;
    end else if (dec && !zero) begin
      // Never wraps below zero; zero is handled as expiry by the owner
      count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - memory-mapped 16-bit interval timer with active-low interrupt
//
// Ports:
//   clk     single clock (PHI_0)
//   rst     synchronous active-high reset
//   ab      processor address bus
//   db_wr   processor write data
//   rw      1 = read, 0 = write
//   db_rd   read data, 0x00 when not selected
//   sel     address hit on the 8-byte register block
//   irq_n   interrupt request, active low
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ab,
  input  logic [7:0]  db_wr,
  input  logic        rw,
  output logic [7:0]  db_rd,
  output logic        sel,
  output logic        irq_n
);

  logic [2:0]   ofs;
  logic         wr_en;
  logic         cnt_l_wr, cnt_h_wr, lat_l_wr, lat_h_wr, ctrl_wr, status_wr;
  logic [15:0]  latch_q;
  logic [2:0]   ctrl_q;
  logic         flag_q;
  logic [15:0]  count;
  logic         zero;
  timer_state_t state_q, state_d;
  logic         expire;
  logic         dec;
  logic         reload;

  assign sel   = (ab[15:3] == BASE_ADDR[15:3]);
  assign ofs   = ab[2:0];
  assign wr_en = sel & ~rw;

  assign cnt_l_wr  = wr_en && (ofs == OFS_CNT_L);
  assign cnt_h_wr  = wr_en && (ofs == OFS_CNT_H);
  assign lat_l_wr  = wr_en && (ofs == OFS_LAT_L);
  assign lat_h_wr  = wr_en && (ofs == OFS_LAT_H);
  assign ctrl_wr   = wr_en && (ofs == OFS_CTRL);
  assign status_wr = wr_en && (ofs == OFS_STATUS);

  // Latch and control registers. A reload in the same cycle as a latch
  // write sees the old latch because the counter samples latch_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= 16'h0000;
      ctrl_q  <= 3'b000;
    end else begin
      if (cnt_l_wr || lat_l_wr) latch_q[7:0]  <= db_wr;
      if (cnt_h_wr || lat_h_wr) latch_q[15:8] <= db_wr;
      if (ctrl_wr)              ctrl_q        <= db_wr[2:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and counter controls. A CNT_H write overrides expiry
  // completely, so expire is only raised when no CNT_H write is present.
  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    dec     = 1'b0;
    if (cnt_h_wr) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (ctrl_q[CTRL_EN]) begin
            if (zero) begin
              expire = 1'b1;
              if (!ctrl_q[CTRL_CONT]) state_d = DONE;
            end else begin
              dec = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
    reload = expire && ctrl_q[CTRL_CONT];
  end

  // Expiry beats a STATUS clear; a CNT_H write beats both
  always_ff @(posedge clk) begin
    if (rst)                          flag_q <= 1'b0;
    else if (cnt_h_wr)                flag_q <= 1'b0;
    else if (expire)                  flag_q <= 1'b1;
    else if (status_wr && db_wr[0])   flag_q <= 1'b0;
  end

  timer_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_h_wr),
    .load_val   ({db_wr, latch_q[7:0]}),
    .reload     (reload),
    .reload_val (latch_q),
    .dec        (dec),
    .count      (count),
    .zero       (zero)
  );

  assign irq_n = ~(flag_q & ctrl_q[CTRL_IE]);

  always_comb begin
    db_rd = 8'h00;
    if (sel) begin
      case (ofs)
        OFS_CNT_L:  db_rd = count[7:0];
        OFS_CNT_H:  db_rd = count[15:8];
        OFS_LAT_L:  db_rd = latch_q[7:0];
        OFS_LAT_H:  db_rd = latch_q[15:8];
        OFS_CTRL:   db_rd = {5'b00000, ctrl_q};
        OFS_STATUS: db_rd = {7'b0000000, flag_q};
        default:    db_rd = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// tb/tb_irq_timer.sv - directed self-checking bench for irq_timer
module tb_irq_timer;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clk;
  logic        rst;
  logic [15:0] ab;
  logic [7:0]  db_wr;
  logic        rw;
  logic [7:0]  db_rd;
  logic        sel;
  logic        irq_n;

  int total;
  int bad;

  irq_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .ab    (ab),
    .db_wr (db_wr),
    .rw    (rw),
    .db_rd (db_rd),
    .sel   (sel),
    .irq_n (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write commits on the next rising edge; returns 1 ns after that edge
  task automatic bus_wr(input logic [2:0] o, input logic [7:0] d);
    ab    = BASE | {13'd0, o};
    db_wr = d;
    rw    = 1'b0;
    @(posedge clk);
    #1;
    rw = 1'b1;
    ab = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] o, output logic [7:0] d);
    ab = BASE | {13'd0, o};
    rw = 1'b1;
    #1;
    d  = db_rd;
  endtask

  task automatic cnt_rd(output logic [15:0] c);
    logic [7:0] lo, hi;
    rd(3'd0, lo);
    rd(3'd1, hi);
    c = {hi, lo};
  endtask

  logic [7:0]  r8;
  logic [15:0] c16;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ab    = 16'h0000;
    db_wr = 8'h00;
    rw    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], r8);
      check($sformatf("reset_reg%0d", i), {8'h00, r8}, 16'h0000);
    end
    check("reset_irq_n", {15'd0, irq_n}, 16'd1);
    ab = 16'hC000; #1;
    check("sel_c000", {15'd0, sel}, 16'd0);
    ab = 16'hD005; #1;
    check("sel_d005", {15'd0, sel}, 16'd1);
    ab = 16'h0000;
    step();

    // One-shot: latch 3, EN+IE
    bus_wr(3'd4, 8'h05);
    bus_wr(3'd2, 8'h03);
    bus_wr(3'd1, 8'h00);           // edge N
    cnt_rd(c16); check("os_cnt_n", c16, 16'd3);
    step(); cnt_rd(c16); check("os_cnt_n1", c16, 16'd2);
    step(); cnt_rd(c16); check("os_cnt_n2", c16, 16'd1);
    step(); cnt_rd(c16); check("os_cnt_n3", c16, 16'd0);
    check("os_irq_n3", {15'd0, irq_n}, 16'd1);
    step();                        // edge N+4
    check("os_irq_n4", {15'd0, irq_n}, 16'd0);
    rd(3'd5, r8); check("os_status", {8'h00, r8}, 16'h0001);
    step(); step();
    cnt_rd(c16); check("os_cnt_hold", c16, 16'd0);
    check("os_irq_hold", {15'd0, irq_n}, 16'd0);
    bus_wr(3'd5, 8'h01);
    check("os_irq_clr", {15'd0, irq_n}, 16'd1);
    rd(3'd5, r8); check("os_status_clr", {8'h00, r8}, 16'h0000);

    // Continuous: latch 4, period 5
    bus_wr(3'd4, 8'h07);
    bus_wr(3'd2, 8'h04);
    bus_wr(3'd3, 8'h00);
    bus_wr(3'd1, 8'h00);           // edge N, counter 4
    step(); step(); step(); step();
    check("ct_irq_pre", {15'd0, irq_n}, 16'd1);
    step();                        // N+5 expiry, reload to 4
    check("ct_irq_first", {15'd0, irq_n}, 16'd0);
    for (int p = 0; p < 4; p++) begin
      bus_wr(3'd5, 8'h01);         // counter 3, FLAG cleared
      check($sformatf("ct_clr_p%0d", p), {15'd0, irq_n}, 16'd1);
      cnt_rd(c16); check($sformatf("ct_cnt_p%0d", p), c16, 16'd3);
      step(); step(); step();
      check($sformatf("ct_quiet_p%0d", p), {15'd0, irq_n}, 16'd1);
      step();
      check($sformatf("ct_fire_p%0d", p), {15'd0, irq_n}, 16'd0);
    end

    // Continuous reload uses pre-write latch
    bus_wr(3'd2, 8'h03);
    bus_wr(3'd1, 8'h00);           // counter 3
    step(); step(); step();        // counter 0
    bus_wr(3'd2, 8'h07);           // expiry edge, latch write
    cnt_rd(c16); check("reload_old_latch", c16, 16'd3);
    rd(3'd2, r8); check("reload_lat_l", {8'h00, r8}, 16'h0007);

    // Pause
    bus_wr(3'd4, 8'h01);
    bus_wr(3'd2, 8'h05);
    bus_wr(3'd1, 8'h01);           // counter 0x0105
    step(); step(); step(); step(); // 0x0101
    bus_wr(3'd4, 8'h00);           // decrements to 0x0100, then EN off
    for (int k = 0; k < 10; k++) begin
      cnt_rd(c16);
      check($sformatf("pause_%0d", k), c16, 16'h0100);
      step();
    end
    bus_wr(3'd4, 8'h01);
    cnt_rd(c16); check("resume_0", c16, 16'h0100);
    step();
    cnt_rd(c16); check("resume_1", c16, 16'h00FF);

    // Collision: STATUS clear on expiry cycle
    bus_wr(3'd4, 8'h05);
    bus_wr(3'd5, 8'h01);
    bus_wr(3'd2, 8'h02);
    bus_wr(3'd1, 8'h00);           // counter 2
    step(); step();                // counter 0
    bus_wr(3'd5, 8'h01);           // expiry edge
    rd(3'd5, r8); check("col_status_set", {8'h00, r8}, 16'h0001);
    check("col_irq", {15'd0, irq_n}, 16'd0);

    // Collision: CNT_H write on expiry cycle
    bus_wr(3'd5, 8'h01);
    bus_wr(3'd2, 8'h02);
    bus_wr(3'd1, 8'h00);           // counter 2
    bus_wr(3'd2, 8'h09);           // counter 1
    step();                        // counter 0
    bus_wr(3'd1, 8'h00);           // expiry edge
    cnt_rd(c16); check("colh_cnt", c16, 16'h0009);
    rd(3'd5, r8); check("colh_flag", {8'h00, r8}, 16'h0000);
    check("colh_irq", {15'd0, irq_n}, 16'd1);
    step();
    cnt_rd(c16); check("colh_run", c16, 16'h0008);

    // Clearing IE releases irq_n, FLAG untouched
    step(); step(); step(); step(); step(); step(); step(); step(); step();
    check("ie_irq_set", {15'd0, irq_n}, 16'd0);
    bus_wr(3'd4, 8'h01);
    check("ie_irq_off", {15'd0, irq_n}, 16'd1);
    rd(3'd5, r8); check("ie_flag_kept", {8'h00, r8}, 16'h0001);

    // Unused offsets and reset mid-count
    bus_wr(3'd6, 8'hFF);
    rd(3'd6, r8); check("ofs6", {8'h00, r8}, 16'h0000);
    bus_wr(3'd4, 8'h07);
    bus_wr(3'd2, 8'h40);
    bus_wr(3'd1, 8'h00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_rd(c16); check("rst_cnt", c16, 16'h0000);
    rd(3'd4, r8); check("rst_ctrl", {8'h00, r8}, 16'h0000);
    rd(3'd2, r8); check("rst_lat", {8'h00, r8}, 16'h0000);
    rd(3'd5, r8); check("rst_flag", {8'h00, r8}, 16'h0000);
    check("rst_irq", {15'd0, irq_n}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
